jtframe_cheat_irom: RTL and testbench



---
 rtl/jtframe_cheat_pkg.sv | 22 ++
 rtl/jtframe_cheat_dpram.sv | 35 +++
 rtl/jtframe_cheat_irom.sv | 115 +++++++++++
 tb/tb_jtframe_cheat_irom.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/jtframe_cheat_pkg.sv
// Shared types and constants for the cheat-engine instruction ROM.
package jtframe_cheat_pkg;

    localparam int unsigned IW             = 18;
    localparam int unsigned BW             = 8;
    localparam int unsigned BYTES_PER_WORD = 3;

    // Byte position within the three-byte instruction being assembled
    typedef enum logic [1:0] {
        PH_B0 = 2'd0,
        PH_B1 = 2'd1,
        PH_B2 = 2'd2
    } phase_t;

    // Instruction word as assembled from the download stream
    typedef struct packed {
        logic [IW-2*BW-1:0] hi;
        logic [BW-1:0]      mid;
        logic [BW-1:0]      lo;
    } iword_t;

endpackage

// File: rtl/jtframe_cheat_dpram.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
module jtframe_cheat_dpram
    import jtframe_cheat_pkg::*;
#(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = IW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Contents survive reset; only the output register is cleared
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Read-first: a colliding write becomes visible on the following fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rdata <= '0;
        else        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/jtframe_cheat_irom.sv
// Cheat CPU instruction memory with byte-serial loader (3 bytes per word).
// Optional JTFRAME_CHEAT_CSUM_EN adds prog_csum / prog_words load statistics.
module jtframe_cheat_irom
    import jtframe_cheat_pkg::*;
#(
    parameter int unsigned AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] iaddr,
    output logic [IW-1:0] idata,
    input  logic          prog_en,
    input  logic          prog_wr,
    input  logic [7:0]    prog_addr,
    input  logic [7:0]    prog_data
`ifdef JTFRAME_CHEAT_CSUM_EN
    ,
    output logic [7:0]    prog_csum,
    output logic [AW:0]   prog_words
`endif
);

    phase_t        r_phase, w_phase_nxt;
    logic [AW-1:0] r_wcnt,  w_wcnt_nxt;
    logic [BW-1:0] r_b0,    w_b0_nxt;
    logic [BW-1:0] r_b1,    w_b1_nxt;
    logic          w_we;
    iword_t        w_wdata;
    logic          w_unused_addr;

    assign w_unused_addr = ^prog_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= PH_B0;
            r_wcnt  <= '0;
            r_b0    <= '0;
            r_b1    <= '0;
        end else begin
            r_phase <= w_phase_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_b0    <= w_b0_nxt;
            r_b1    <= w_b1_nxt;
        end
    end

    // Loader: a dropped prog_en discards any partial word and rewinds to word 0
    always_comb begin
        w_phase_nxt = r_phase;
        w_wcnt_nxt  = r_wcnt;
        w_b0_nxt    = r_b0;
        w_b1_nxt    = r_b1;
        w_we        = 1'b0;
        w_wdata     = {prog_data[1:0], r_b1, r_b0};
        if (!prog_en) begin
            w_phase_nxt = PH_B0;
            w_wcnt_nxt  = '0;
        end else if (prog_wr) begin
            case (r_phase)
                PH_B0: begin
                    w_b0_nxt    = prog_data;
                    w_phase_nxt = PH_B1;
                end
                PH_B1: begin
                    w_b1_nxt    = prog_data;
                    w_phase_nxt = PH_B2;
                end
                PH_B2: begin
                    w_we        = 1'b1;
                    w_phase_nxt = PH_B0;
                    w_wcnt_nxt  = r_wcnt + AW'(1);
                end
                default: w_phase_nxt = PH_B0;
            endcase
        end
    end

    jtframe_cheat_dpram #(
        .AW (AW),
        .DW (IW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_waddr (r_wcnt),
        .i_wdata (w_wdata),
        .i_raddr (iaddr),
        .o_rdata (idata)
    );

`ifdef JTFRAME_CHEAT_CSUM_EN
    localparam logic [AW:0] WORDS_MAX = {1'b1, {AW{1'b0}}};

    logic [7:0]  r_csum;
    logic [AW:0] r_words;

    // Load statistics, saturating word count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csum  <= '0;
            r_words <= '0;
        end else if (!prog_en) begin
            r_csum  <= '0;
            r_words <= '0;
        end else begin
            if (prog_wr) r_csum <= r_csum + prog_data;
            if (w_we && r_words != WORDS_MAX) r_words <= r_words + (AW+1)'(1);
        end
    end

    assign prog_csum  = r_csum;
    assign prog_words = r_words;
`endif

endmodule

// File: tb/tb_jtframe_cheat_irom.sv
// Directed bench for jtframe_cheat_irom (AW=10 main instance, AW=2 wrap instance).
module tb_jtframe_cheat_irom;

    logic        clk;
    logic        rst_n;
    logic [9:0]  iaddr;
    logic [17:0] idata;
    logic        prog_en, prog_wr;
    logic [7:0]  prog_data;
    logic [1:0]  s_iaddr;
    logic [17:0] s_idata;
    logic        s_prog_en, s_prog_wr;
    logic [7:0]  s_prog_data;
`ifdef JTFRAME_CHEAT_CSUM_EN
    logic [7:0]  prog_csum, s_prog_csum;
    logic [10:0] prog_words;
    logic [2:0]  s_prog_words;
`endif

    int errors = 0;
    int checks = 0;

    jtframe_cheat_irom #(.AW(10)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .iaddr      (iaddr),
        .idata      (idata),
        .prog_en    (prog_en),
        .prog_wr    (prog_wr),
        .prog_addr  (8'h5A),
        .prog_data  (prog_data)
`ifdef JTFRAME_CHEAT_CSUM_EN
        ,
        .prog_csum  (prog_csum),
        .prog_words (prog_words)
`endif
    );

    jtframe_cheat_irom #(.AW(2)) u_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .iaddr      (s_iaddr),
        .idata      (s_idata),
        .prog_en    (s_prog_en),
        .prog_wr    (s_prog_wr),
        .prog_addr  (8'hA5),
        .prog_data  (s_prog_data)
`ifdef JTFRAME_CHEAT_CSUM_EN
        ,
        .prog_csum  (s_prog_csum),
        .prog_words (s_prog_words)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, exp completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %05h exp %05h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] b);
        @(negedge clk);
        if (sel) begin s_prog_wr = 1'b1; s_prog_data = b; end
        else     begin prog_wr   = 1'b1; prog_data   = b; end
        @(negedge clk);
        if (sel) s_prog_wr = 1'b0;
        else     prog_wr   = 1'b0;
    endtask

    task automatic restart(input bit sel);
        @(negedge clk);
        if (sel) s_prog_en = 1'b0; else prog_en = 1'b0;
        @(negedge clk);
        if (sel) s_prog_en = 1'b1; else prog_en = 1'b1;
    endtask

    task automatic rd(input bit sel, input int unsigned addr, input string tag, input logic [17:0] exp);
        @(negedge clk);
        if (sel) s_iaddr = 2'(addr); else iaddr = 10'(addr);
        @(negedge clk);
        check(tag, sel ? s_idata : idata, exp);
    endtask

    initial begin
        rst_n = 1'b1;
        iaddr = '0; prog_en = 1'b0; prog_wr = 1'b0; prog_data = '0;
        s_iaddr = '0; s_prog_en = 1'b0; s_prog_wr = 1'b0; s_prog_data = '0;

        // Reset asserted mid-cycle clears outputs immediately
        #2 rst_n = 1'b0;
        #1;
        check("reset_idata", idata, 18'h0);
        check("reset_s_idata", s_idata, 18'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic load; prog_data[7:2] of the third byte is dropped
        restart(1'b0);
        send_byte(1'b0, 8'h34); send_byte(1'b0, 8'h12); send_byte(1'b0, 8'hFF);
        rd(1'b0, 0, "basic_w0", 18'h31234);
`ifdef JTFRAME_CHEAT_CSUM_EN
        check("basic_csum", 18'(prog_csum), 18'h45);
        check("basic_words", 18'(prog_words), 18'h1);
`endif

        // Sequential load, then a third word proves wcnt reached 2
        restart(1'b0);
        send_byte(1'b0, 8'h01); send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h00);
        send_byte(1'b0, 8'h02); send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h01);
        send_byte(1'b0, 8'h56); send_byte(1'b0, 8'h34); send_byte(1'b0, 8'h02);
        rd(1'b0, 0, "seq_w0", 18'h00001);
        rd(1'b0, 1, "seq_w1", 18'h10002);
        rd(1'b0, 2, "seq_w2", 18'h23456);

        // Reset mid-cycle: idata clears, memory contents survive
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_idata", idata, 18'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(1'b0, 1, "kept_w1", 18'h10002);
        rd(1'b0, 2, "kept_w2", 18'h23456);

        // Partial word is discarded when prog_en drops
        restart(1'b0);
        send_byte(1'b0, 8'h11); send_byte(1'b0, 8'h22);
        restart(1'b0);
        send_byte(1'b0, 8'hAA); send_byte(1'b0, 8'hBB); send_byte(1'b0, 8'h00);
        rd(1'b0, 0, "partial_w0", 18'h0BBAA);
        rd(1'b0, 1, "partial_w1", 18'h10002);

        // Read-first collision on word 5: seed a known old value first
        restart(1'b0);
        for (int i = 0; i < 15; i++) send_byte(1'b0, 8'(i));
        send_byte(1'b0, 8'hAB); send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h00);
        rd(1'b0, 5, "coll_seed", 18'h000AB);
        restart(1'b0);
        for (int i = 0; i < 15; i++) send_byte(1'b0, 8'(i));
        send_byte(1'b0, 8'hCD); send_byte(1'b0, 8'hEF);
        @(negedge clk);
        iaddr = 10'd5; prog_wr = 1'b1; prog_data = 8'h03;
        @(negedge clk);
        prog_wr = 1'b0;
        check("coll_old", idata, 18'h000AB);
        @(negedge clk);
        check("coll_new", idata, 18'h3EFCD);

        // Wrap on the AW=2 instance: 5th word overwrites word 0
        restart(1'b1);
        for (int i = 0; i < 15; i++) send_byte(1'b1, 8'(8'h10 + i));
        rd(1'b1, 0, "wrap_w0", 18'h21D1C);
        rd(1'b1, 1, "wrap_w1", 18'h11413);
        rd(1'b1, 2, "wrap_w2", 18'h01716);
        rd(1'b1, 3, "wrap_w3", 18'h31A19);
`ifdef JTFRAME_CHEAT_CSUM_EN
        check("wrap_words_sat", 18'(s_prog_words), 18'h4);

        // Checksum modulo 256 and clearing on prog_en low
        restart(1'b0);
        send_byte(1'b0, 8'h80); send_byte(1'b0, 8'h80); send_byte(1'b0, 8'h01);
        @(negedge clk);
        check("csum_val", 18'(prog_csum), 18'h01);
        check("csum_words", 18'(prog_words), 18'h1);
        prog_en = 1'b0;
        @(negedge clk);
        check("csum_clr", 18'(prog_csum), 18'h0);
        check("words_clr", 18'(prog_words), 18'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
